// File: rtl/cve2_fetch_req_ctrl.sv
// Fetch request sequencer: issues word-aligned OBI instruction fetches, tracks
// outstanding responses in order, and forwards only responses not made stale by a branch.
module cve2_fetch_req_ctrl #(
    parameter int unsigned NUM_REQS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic                branch_i,
    input  logic [31:0]         addr_i,
    output logic                busy_o,
    input  logic [NUM_REQS-1:0] fifo_busy_i,
    output logic                fifo_clear_o,
    output logic                fifo_valid_o,
    output logic [31:0]         fifo_addr_o,
    output logic [31:0]         fifo_rdata_o,
    output logic                fifo_err_o,
    output logic                instr_req_o,
    input  logic                instr_gnt_i,
    output logic [31:0]         instr_addr_o,
    input  logic                instr_rvalid_i,
    input  logic [31:0]         instr_rdata_i,
    input  logic                instr_err_i
);

    typedef enum logic {
        IDLE,
        WAIT_GNT
    } state_e;

    typedef struct packed {
        logic valid;
        logic discard;
    } slot_t;

    localparam int unsigned CNT_W = $clog2(NUM_REQS + 1) + 1;

    state_e                     state_q, state_d;
    logic [31:0]                fetch_addr_q, fetch_addr_d;
    logic [31:0]                wait_addr_q, wait_addr_d;
    logic                       wait_stale_q, wait_stale_d;
    slot_t [NUM_REQS-1:0]       slots_q, slots_d;

    logic [CNT_W-1:0]           out_cnt, fifo_cnt;
    logic [NUM_REQS-1:0]        slot_valid;
    logic                       credit_ok;
    logic [31:0]                branch_addr;
    logic [31:0]                req_addr;
    logic                       push, push_discard;

    assign branch_addr = {addr_i[31:2], 2'b00};

    always_comb begin
        out_cnt  = '0;
        fifo_cnt = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            slot_valid[i] = slots_q[i].valid;
            out_cnt       = out_cnt + CNT_W'(slots_q[i].valid);
            fifo_cnt      = fifo_cnt + CNT_W'(fifo_busy_i[i]);
        end
        // A branch clears the FIFO in the same cycle, so its occupancy frees up.
        credit_ok = req_i && ((out_cnt + (branch_i ? '0 : fifo_cnt)) < CNT_W'(NUM_REQS));
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        wait_addr_d  = wait_addr_q;
        wait_stale_d = wait_stale_q;
        instr_req_o  = 1'b0;
        req_addr     = fetch_addr_q;
        push         = 1'b0;
        push_discard = 1'b0;

        unique case (state_q)
            IDLE: begin
                instr_req_o = credit_ok;
                req_addr    = branch_i ? branch_addr : fetch_addr_q;
                if (branch_i) begin
                    fetch_addr_d = branch_addr;
                end
                if (credit_ok) begin
                    if (instr_gnt_i) begin
                        push         = 1'b1;
                        fetch_addr_d = req_addr + 32'd4;
                    end else begin
                        state_d      = WAIT_GNT;
                        wait_addr_d  = req_addr;
                        wait_stale_d = 1'b0;
                    end
                end
            end
            WAIT_GNT: begin
                // The bus request cannot be withdrawn; a branch only marks it stale.
                instr_req_o = 1'b1;
                req_addr    = wait_addr_q;
                if (branch_i) begin
                    fetch_addr_d = branch_addr;
                    wait_stale_d = 1'b1;
                end
                if (instr_gnt_i) begin
                    push         = 1'b1;
                    push_discard = wait_stale_q | branch_i;
                    state_d      = IDLE;
                    if (!(wait_stale_q | branch_i)) begin
                        fetch_addr_d = wait_addr_q + 32'd4;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic placed;
        slots_d = slots_q;
        placed  = 1'b0;
        if (branch_i) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                slots_d[i].discard = slots_q[i].discard | slots_q[i].valid;
            end
        end
        if (instr_rvalid_i) begin
            for (int i = 0; i < NUM_REQS - 1; i++) begin
                slots_d[i] = slots_d[i + 1];
            end
            slots_d[NUM_REQS-1] = '0;
        end
        if (push) begin
            for (int i = 0; i < NUM_REQS; i++) begin
                if (!placed && !slots_d[i].valid) begin
                    slots_d[i].valid   = 1'b1;
                    slots_d[i].discard = push_discard;
                    placed             = 1'b1;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            wait_addr_q  <= '0;
            wait_stale_q <= 1'b0;
            // NOTE: only the valid/discard flags need reset; no data is stored per slot.
            slots_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            wait_addr_q  <= wait_addr_d;
            wait_stale_q <= wait_stale_d;
            slots_q      <= slots_d;
        end
    end

    assign instr_addr_o = req_addr;
    assign busy_o       = (state_q == WAIT_GNT) | (|slot_valid);
    assign fifo_clear_o = branch_i;
    assign fifo_addr_o  = addr_i;
    assign fifo_valid_o = instr_rvalid_i & slots_q[0].valid & ~slots_q[0].discard & ~branch_i;
    assign fifo_rdata_o = instr_rdata_i;
    assign fifo_err_o   = instr_err_i;

`ifndef SYNTHESIS
    a_no_gnt_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_o && instr_gnt_i) |-> !(&slot_valid));
    a_no_rvalid_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
        instr_rvalid_i |-> (|slot_valid));
    a_addr_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (instr_req_o && !instr_gnt_i) |=> (instr_req_o && $stable(instr_addr_o)));
`endif

endmodule

// File: tb/tb_cve2_fetch_req_ctrl.sv
// Randomized scoreboard bench for cve2_fetch_req_ctrl: a transaction-level memory and
// fetch-stream model predicts requests and which responses must reach the FIFO.
module tb_cve2_fetch_req_ctrl;

    localparam int unsigned NUM_REQS = 2;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                req_i;
    logic                branch_i;
    logic [31:0]         addr_i;
    logic                busy_o;
    logic [NUM_REQS-1:0] fifo_busy_i;
    logic                fifo_clear_o;
    logic                fifo_valid_o;
    logic [31:0]         fifo_addr_o;
    logic [31:0]         fifo_rdata_o;
    logic                fifo_err_o;
    logic                instr_req_o;
    logic                instr_gnt_i;
    logic [31:0]         instr_addr_o;
    logic                instr_rvalid_i;
    logic [31:0]         instr_rdata_i;
    logic                instr_err_i;

    cve2_fetch_req_ctrl #(.NUM_REQS(NUM_REQS)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .branch_i       (branch_i),
        .addr_i         (addr_i),
        .busy_o         (busy_o),
        .fifo_busy_i    (fifo_busy_i),
        .fifo_clear_o   (fifo_clear_o),
        .fifo_valid_o   (fifo_valid_o),
        .fifo_addr_o    (fifo_addr_o),
        .fifo_rdata_o   (fifo_rdata_o),
        .fifo_err_o     (fifo_err_o),
        .instr_req_o    (instr_req_o),
        .instr_gnt_i    (instr_gnt_i),
        .instr_addr_o   (instr_addr_o),
        .instr_rvalid_i (instr_rvalid_i),
        .instr_rdata_i  (instr_rdata_i),
        .instr_err_i    (instr_err_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          live;
    } mem_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    mem_t        memq[$];   // granted requests awaiting a bus response, oldest first
    rsp_t        exp_q[$];  // responses that must appear on the FIFO port
    bit          stalled, stalled_stale;
    logic [31:0] stalled_addr, next_addr;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every live response must appear on the FIFO port in order, nothing else.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk_i);
            if (exp_q.size() > 0 || fifo_valid_o === 1'b1) begin
                check("fifo_valid_o", fifo_valid_o, exp_q.size() > 0);
                if (exp_q.size() > 0) begin
                    r = exp_q.pop_front();
                    if (fifo_valid_o === 1'b1) begin
                        check("fifo_rdata_o", fifo_rdata_o, r.rdata);
                        check("fifo_err_o", fifo_err_o, r.err);
                    end
                end
            end
        end
    end

    task automatic cycle(input int p_req, input int p_gnt, input int p_rv, input int p_br,
                         input int p_busy, input bit force_br, input logic [31:0] br_addr,
                         input bit in_rst);
        bit          exp_req;
        logic [31:0] exp_a, tgt, rnd;
        mem_t        m;

        @(posedge clk_i);
        #1;
        rst_ni   = !in_rst;
        req_i    = !in_rst && ($urandom_range(99) < p_req);
        branch_i = !in_rst && (force_br || ($urandom_range(99) < p_br));
        rnd      = $urandom();
        addr_i   = force_br ? br_addr : {rnd[31:1], 1'b0};
        for (int i = 0; i < NUM_REQS; i++) fifo_busy_i[i] = ($urandom_range(99) < p_busy);
        instr_rvalid_i = !in_rst && memq.size() > 0 && ($urandom_range(99) < p_rv);
        if (instr_rvalid_i) begin
            instr_rdata_i = memq[0].rdata;
            instr_err_i   = memq[0].err;
            if (memq[0].live && !branch_i) exp_q.push_back('{memq[0].rdata, memq[0].err});
        end else begin
            instr_rdata_i = $urandom();
            instr_err_i   = $urandom_range(1);
        end
        #1;
        instr_gnt_i = !in_rst && (instr_req_o === 1'b1) && ($urandom_range(99) < p_gnt);

        @(negedge clk_i);
        if (in_rst) begin
            memq.delete();
            stalled   = 0;
            next_addr = '0;
            return;
        end

        tgt     = {addr_i[31:2], 2'b00};
        exp_req = stalled ||
                  (req_i && (memq.size() + (branch_i ? 0 : $countones(fifo_busy_i))) < NUM_REQS);
        exp_a   = stalled ? stalled_addr : (branch_i ? tgt : next_addr);
        check("instr_req_o", instr_req_o, exp_req);
        if (exp_req) check("instr_addr_o", instr_addr_o, exp_a);
        check("busy_o", busy_o, stalled || memq.size() > 0);
        check("fifo_clear_o", fifo_clear_o, branch_i);
        check("fifo_addr_o", fifo_addr_o, addr_i);
        if (instr_rvalid_i) check("fifo_rdata_o passthrough", fifo_rdata_o, instr_rdata_i);

        if (instr_rvalid_i) void'(memq.pop_front());
        if (branch_i) foreach (memq[i]) memq[i].live = 0;
        if (instr_gnt_i && exp_req) begin
            m.rdata = $urandom();
            m.err   = ($urandom_range(7) == 0);
            if (stalled) begin
                m.live = !(stalled_stale || branch_i);
                if (m.live) next_addr = exp_a + 32'd4;
                else if (branch_i) next_addr = tgt;
                stalled = 0;
            end else begin
                m.live    = 1;
                next_addr = exp_a + 32'd4;
            end
            memq.push_back(m);
        end else if (exp_req) begin
            if (stalled) begin
                if (branch_i) begin
                    stalled_stale = 1;
                    next_addr     = tgt;
                end
            end else begin
                stalled       = 1;
                stalled_addr  = exp_a;
                stalled_stale = 0;
                if (branch_i) next_addr = tgt;
            end
        end else if (branch_i) begin
            next_addr = tgt;
        end
    endtask

    initial begin
        rst_ni = 1'b0; req_i = 1'b0; branch_i = 1'b0; addr_i = '0; fifo_busy_i = '0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
        stalled = 0; stalled_stale = 0; stalled_addr = '0; next_addr = '0;

        repeat (3) cycle(0, 0, 0, 0, 0, 0, '0, 1);
        cycle(0, 100, 0, 0, 0, 0, '0, 0);                  // reset state

        cycle(100, 100, 100, 0, 0, 1, 32'h100, 0);         // stream from 0x100
        repeat (8) cycle(100, 100, 100, 0, 0, 0, '0, 0);

        repeat (6) cycle(100, 100, 0, 0, 0, 0, '0, 0);     // credit limit, no responses
        repeat (4) cycle(0, 100, 100, 0, 0, 0, '0, 0);

        repeat (3) cycle(100, 100, 0, 0, 0, 0, '0, 0);     // stale responses after branch
        cycle(100, 100, 0, 0, 0, 1, 32'h202, 0);
        repeat (4) cycle(100, 100, 100, 0, 0, 0, '0, 0);

        repeat (2) cycle(100, 0, 100, 0, 0, 0, '0, 0);     // branch while waiting for grant
        cycle(100, 0, 100, 0, 0, 1, 32'h300, 0);
        cycle(100, 0, 100, 0, 0, 0, '0, 0);
        repeat (5) cycle(100, 100, 100, 0, 0, 0, '0, 0);

        repeat (3) cycle(100, 100, 100, 0, 0, 0, '0, 0);   // branch + rvalid + gnt together
        cycle(100, 100, 100, 0, 0, 1, 32'h400, 0);
        repeat (3) cycle(100, 100, 100, 0, 0, 0, '0, 0);

        repeat (2) cycle(100, 100, 0, 0, 0, 0, '0, 0);     // reset mid-burst
        cycle(0, 0, 0, 0, 0, 0, '0, 1);
        cycle(0, 100, 0, 0, 0, 0, '0, 0);
        cycle(100, 100, 100, 0, 0, 1, 32'h500, 0);
        repeat (4) cycle(100, 100, 100, 0, 0, 0, '0, 0);

        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 499) begin
                cycle(80, 100, 50, 5, 20, 0, '0, 0);
                cycle(0, 0, 0, 0, 0, 0, '0, 1);
            end else begin
                cycle(80, 60, 50, 5, 20, 0, '0, 0);
            end
        end

        repeat (6) cycle(0, 100, 100, 0, 0, 0, '0, 0);     // drain
        check("responses drained", memq.size(), 0);

        @(negedge clk_i);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
